// File: rtl/light_arbiter_if.sv
// rtl/light_arbiter_if.sv - sensor inputs and light outputs of the intersection arbiter
//   sensor_light[7:0]     approach sensors (N=[6], E=[5], S=[4], W=[7])
//   general_sensors[31:0] user sensors, not used by the arbiter
//   outN/outS/outE/outW   3-bit light codes (Stop=000, Go=100)
//   grant[3:0]            one-hot Go holder {W,S,E,N}
interface light_arbiter_if;
    logic [7:0]  sensor_light;
    logic [31:0] general_sensors;
    logic [2:0]  outN;
    logic [2:0]  outS;
    logic [2:0]  outE;
    logic [2:0]  outW;
    logic [3:0]  grant;

    modport master (
        output sensor_light, general_sensors,
        input  outN, outS, outE, outW, grant
    );

    modport slave (
        input  sensor_light, general_sensors,
        output outN, outS, outE, outW, grant
    );
endinterface

// File: rtl/light_arbiter.sv
// rtl/light_arbiter.sv - demand-driven round-robin four-way light controller
//   clk  rising-edge system clock
//   rst  asynchronous active-high reset
//   bus  light_arbiter_if.slave: sensors in, four light codes and one-hot grant out
module light_arbiter #(
    parameter int MIN_GREEN    = 8,
    parameter int MAX_GREEN    = 64,
    parameter int CLEAR_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    light_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, GREEN, CLEAR} state_t;

    localparam logic [7:0] MIN_M1   = 8'(MIN_GREEN - 1);
    localparam logic [7:0] MAX_M1   = 8'(MAX_GREEN - 1);
    localparam logic [7:0] CLEAR_M1 = 8'(CLEAR_CYCLES - 1);
    localparam logic [2:0] GO       = 3'b100;

    state_t      state_q;
    logic [1:0]  last_q;    // direction index: 0=N 1=E 2=S 3=W (round-robin order)
    logic [7:0]  cnt_q;
    logic [3:0]  grant_q;
    logic [11:0] lights_q;  // {W,S,E,N} light codes, 3 bits each

    // Requests reordered so that index == round-robin position == grant bit.
    logic [3:0] req;
    assign req = {bus.sensor_light[7], bus.sensor_light[4],
                  bus.sensor_light[5], bus.sensor_light[6]};

    logic unused_inputs;
    assign unused_inputs = ^{bus.general_sensors, bus.sensor_light[3:0]};

    // Winner: nearest requester after last_q; last_q itself is the final candidate,
    // so it only wins again when nobody else is asking.
    logic       win_valid;
    logic [1:0] win_idx;
    logic [1:0] cand;
    always_comb begin
        win_valid = 1'b0;
        win_idx   = last_q;
        cand      = last_q;
        for (int k = 4; k >= 1; k--) begin
            cand = last_q + 2'(k);
            if (req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // In GREEN, last_q is the current holder.
    logic own;
    logic other;
    logic green_exit;
    always_comb begin
        own        = req[last_q];
        other      = |(req & ~(4'b0001 << last_q));
        green_exit = (cnt_q >= MIN_M1) && other && (!own || (cnt_q >= MAX_M1));
    end

    function automatic logic [11:0] go_lights(input logic [1:0] idx);
        logic [11:0] l;
        l = '0;
        l[3*idx +: 3] = GO;
        return l;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= 2'd3;
            cnt_q    <= '0;
            grant_q  <= '0;
            lights_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        state_q  <= GREEN;
                        last_q   <= win_idx;
                        cnt_q    <= '0;
                        grant_q  <= 4'b0001 << win_idx;
                        lights_q <= go_lights(win_idx);
                    end
                end
                GREEN: begin
                    if (green_exit) begin
                        state_q  <= CLEAR;
                        cnt_q    <= '0;
                        grant_q  <= '0;
                        lights_q <= '0;
                    end else if (cnt_q != 8'hFF) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                CLEAR: begin
                    if (cnt_q == CLEAR_M1) begin
                        cnt_q <= '0;
                        if (win_valid) begin
                            state_q  <= GREEN;
                            last_q   <= win_idx;
                            grant_q  <= 4'b0001 << win_idx;
                            lights_q <= go_lights(win_idx);
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    cnt_q    <= '0;
                    grant_q  <= '0;
                    lights_q <= '0;
                end
            endcase
        end
    end

    assign bus.grant = grant_q;
    assign bus.outN  = lights_q[2:0];
    assign bus.outE  = lights_q[5:3];
    assign bus.outS  = lights_q[8:6];
    assign bus.outW  = lights_q[11:9];
endmodule

// File: tb/tb_light_arbiter.sv
// tb/tb_light_arbiter.sv - self-checking bench for light_arbiter
module tb_light_arbiter;
    localparam int MIN_G = 8;
    localparam int MAX_G = 64;
    localparam int CLR   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    light_arbiter_if bus ();

    light_arbiter #(.MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .CLEAR_CYCLES(CLR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: direction index 0=N 1=E 2=S 3=W.
    int m_holder;   // -1 when nobody holds Go
    int m_last;
    int m_glen;     // Go cycles shown so far by the holder
    bit m_clear;
    int m_cdone;    // Stop cycles shown so far in the clearance

    task automatic model_reset();
        m_holder = -1;
        m_last   = 3;
        m_glen   = 0;
        m_clear  = 1'b0;
        m_cdone  = 0;
    endtask

    task automatic model_grant(input logic [3:0] r);
        m_holder = -1;
        for (int k = 1; k <= 4; k++) begin
            int d;
            d = (m_last + k) % 4;
            if (r[d] && m_holder < 0) m_holder = d;
        end
        if (m_holder >= 0) begin
            m_last = m_holder;
            m_glen = 1;
        end
    endtask

    task automatic model_step(input logic [3:0] r);
        if (m_holder >= 0) begin
            bit own;
            bit other;
            own   = r[m_holder];
            other = 1'b0;
            for (int d = 0; d < 4; d++)
                if (d != m_holder && r[d]) other = 1'b1;
            if (m_glen >= MIN_G && other && (!own || m_glen >= MAX_G)) begin
                m_holder = -1;
                m_clear  = 1'b1;
                m_cdone  = 1;
            end else begin
                m_glen++;
            end
        end else if (m_clear) begin
            if (m_cdone == CLR) begin
                m_clear = 1'b0;
                model_grant(r);
            end else begin
                m_cdone++;
            end
        end else begin
            model_grant(r);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [3:0]  eg;
        logic [11:0] el;
        int          gos;
        eg = '0;
        el = '0;
        if (m_holder >= 0) begin
            eg[m_holder] = 1'b1;
            el[3*m_holder +: 3] = 3'b100;
        end
        gos = int'(bus.outN == 3'b100) + int'(bus.outE == 3'b100) +
              int'(bus.outS == 3'b100) + int'(bus.outW == 3'b100);
        chk("grant", 32'(bus.grant), 32'(eg));
        chk("lights", 32'({bus.outW, bus.outS, bus.outE, bus.outN}), 32'(el));
        chk("single_go", 32'(gos <= 1), 32'd1);
    endtask

    // r = {W,S,E,N}; applied at a falling edge, sampled at the next rising edge.
    task automatic tick(input logic [3:0] r);
        bus.sensor_light    = {r[3], r[0], r[1], r[2], 4'($urandom)};
        bus.general_sensors = $urandom;
        model_step(r);
        @(negedge clk);
        check_all();
    endtask

    task automatic sync_reset();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_all();
    endtask

    logic [3:0] rq;
    int         bound;

    initial begin
        bus.sensor_light    = '0;
        bus.general_sensors = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_grant", 32'(bus.grant), 32'd0);
        chk("reset_lights", 32'({bus.outW, bus.outS, bus.outE, bus.outN}), 32'd0);
        rst = 1'b0;
        check_all();

        // Single East request, no competition: E holds Go indefinitely.
        tick(4'b0010);
        chk("east_first", 32'(bus.grant), 32'b0010);
        repeat (200) tick(4'b0010);
        chk("east_held", 32'(bus.outE), 32'b100);

        // Asynchronous reset between edges while E is green.
        #2 rst = 1'b1;
        #1;
        chk("async_grant", 32'(bus.grant), 32'd0);
        chk("async_lights", 32'({bus.outW, bus.outS, bus.outE, bus.outN}), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_all();

        // N and E together after reset: N first.
        tick(4'b0011);
        chk("rr_after_reset", 32'(bus.grant), 32'b0001);
        repeat (4) tick(4'b0011);

        // N vs S until clearance, then demand vanishes.
        bound = 0;
        while (bus.grant != 4'b0000 && bound < 200) begin
            tick(4'b0101);
            bound++;
        end
        chk("reach_clear", 32'(bus.grant), 32'd0);
        repeat (10) tick(4'b0000);
        chk("idle_after_clear", 32'(bus.grant), 32'd0);
        tick(4'b0100);
        chk("south_from_idle", 32'(bus.grant), 32'b0100);

        // Minimum green: N pulse, S arrives after 3 cycles.
        sync_reset();
        tick(4'b0001);
        repeat (2) tick(4'b0000);
        repeat (30) tick(4'b0100);
        chk("min_green_south", 32'(bus.grant), 32'b0100);

        // Max green with N and W, then full four-way fairness.
        sync_reset();
        repeat (300) tick(4'b1001);
        repeat (600) tick(4'b1111);

        // Randomised request traffic.
        rq = 4'($urandom);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) rq[$urandom_range(3)] = ~rq[$urandom_range(3)];
            if ($urandom_range(31) == 0) rq = 4'($urandom);
            tick(rq);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/light_arbiter.md
# light_arbiter

Demand-driven, four-way intersection light controller for the simulator's per-light slot. It drives outN/outS/outE/outW with the standard 3-bit light codes and grants Go to exactly one direction at a time. Grants are taken from the light's own approach sensors under round-robin arbitration, with a minimum green time, a maximum green time while others wait, and an all-Stop clearance interval between grants. It replaces the fixed-rotation sequencer where traffic is uneven.

## Interface
- MIN_GREEN, 8: minimum cycles a granted direction holds Go; legal range 1..255.
- MAX_GREEN, 64: cycles after which Go is revoked if another direction is waiting; MIN_GREEN ≤ MAX_GREEN ≤ 255.
- CLEAR_CYCLES, 4: all-Stop cycles between two grants; legal range 1..255.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- sensor_light  in  8  light sensors. Request map: reqN=[6], reqS=[4], reqE=[5], reqW=[7]. Other bits are ignored.
- general_sensors  in  32  user-placed sensors; reserved, ignored by this block.
- outN, outS, outE, outW  out  3 each  light codes: Stop=000, Forward_only=001, Left_only=010, Right_only=011, Go=100. This block emits only Stop and Go.
- grant  out  4  one-hot current Go holder {W,S,E,N}; 0 when no direction holds Go.

## Operation
- States:
  - IDLE: all outputs Stop, grant=0.
  - GREEN: one direction at Go.
  - CLEAR: all outputs Stop, grant=0.
- Round-robin order is N→E→S→W→N.
  - `last` register holds the most recently granted direction; it resets to W, so N has first priority.
  - Winner = first direction after `last`, in order, with its request high.
- IDLE: if any request is high, go to GREEN with the winner, load `last`, and clear `cnt`. Otherwise stay in IDLE.
- GREEN:
  - `cnt` (8-bit) increments each cycle and saturates at 255.
  - `own` = request of the granted direction.
  - `other` = OR of the other three requests.
  - Exit to CLEAR when cnt ≥ MIN_GREEN-1, other=1, and (own=0 or cnt ≥ MAX_GREEN-1). Clear `cnt` on exit.
  - If other=0, remain in GREEN indefinitely, regardless of `own`.
- CLEAR:
  - `cnt` increments.
  - When cnt = CLEAR_CYCLES-1, arbitrate:
    - winner exists → GREEN with that winner, load `last`, clear `cnt`;
    - no winner → IDLE.
  - The winner may be the previously granted direction only if no other direction requests. Round-robin skips non-requesters.
- Invariant: at most one out* equals Go in any cycle, and grant matches the Go output.
- Requests are sampled combinationally at the clock edge; there is no input synchronizer (sensors are simulator-synchronous).

## Timing
- Reset (async, any state): state=IDLE, `last`=W, cnt=0, all out*=Stop, grant=0. Outputs go to Stop immediately on rst rise, not at the next edge.
- All outputs are registered and change only on a clk edge or on rst.
- IDLE→Go latency: request high at edge k → Go visible after edge k, i.e. 1 cycle.
- Green length: Go lasts at least MIN_GREEN cycles. With competing demand and `own` held high, Go lasts exactly MAX_GREEN cycles.
- Clearance: exactly CLEAR_CYCLES all-Stop cycles follow every GREEN exit. No Go ever overlaps across directions.
- Request dropped mid-MIN_GREEN: Go is still held until MIN_GREEN has elapsed.
- Simultaneous requests from IDLE: the round-robin from `last` decides (after reset: N, then E, S, W).
- Reset released mid-phase: restarts from IDLE; no partial green is resumed.

## Test plan
- Reset then a single request:
  - Stimulus: rst pulse; sensor_light[5]=1 from cycle 0.
  - Response: outE=Go from cycle 1, grant=0010; outE stays Go with no other demand for 200 cycles.
- Min green with no competitor (defaults):
  - Stimulus: reqN pulse for 1 cycle.
  - Response: outN=Go and holds indefinitely (no other demand).
  - Follow-up: assert reqS after 3 cycles → outN stays Go until MIN_GREEN (8) cycles total, then 4 Stop cycles, then outS=Go.
- Max green:
  - Stimulus: reqN and reqW both held high.
  - Response: outN=Go for exactly 64 cycles, 4 all-Stop cycles, outW=Go for 64 cycles, 4 Stop, outN=Go again.
- Round-robin fairness:
  - Stimulus: all four requests held high.
  - Response: grant sequence N,E,S,W,N…, each 64 cycles Go separated by 4 Stop cycles; no two Go in the same cycle.
- Demand vanishes during clearance:
  - Stimulus: all requests drop during CLEAR.
  - Response: IDLE with all Stop. A later reqS → outS=Go 1 cycle after the request.
- Async reset mid-green:
  - Stimulus: rst asserted between edges while outE=Go.
  - Response: all out* = Stop immediately and grant=0. After release with reqN and reqE both high, N is granted first.
